// File: rtl/pokey_kbd_scan.sv
// pokey_kbd_scan
// ---------------------------------------------------------------------------
// Keyboard scan and debounce controller for the POKEY core.
//
// The block walks a 6-bit scan address across the keyboard matrix and
// samples two return lines. A small compare-latch state machine debounces
// key presses and releases. Accepted keys, status bits and interrupt pulses
// are handed to the register file.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   enp        : scan-rate enable, one scan step per clk with enp=1
//   scan_en    : SKCTL bit 1, 0 holds the scanner idle (synchronous)
//   deb_en     : SKCTL bit 0, 1 enables debounce
//   kr1_n      : key return for the current scan address, active low
//   kr2_n      : modifier / BREAK return, active low
//   k          : scan address driven to the keyboard matrix
//   kbcode     : {ctrl, shift, code[5:0]} of the last accepted key
//   key_down   : SKSTAT key-depressed flag, active high
//   shift_down : SKSTAT shift-depressed flag, active high
//   kbd_irq    : one-clk pulse when a key is accepted
//   brk_irq    : one-clk pulse when BREAK is pressed
// ---------------------------------------------------------------------------
module pokey_kbd_scan #(
   parameter logic [5:0] SHIFT_ADDR = 6'h10,
   parameter logic [5:0] CTRL_ADDR  = 6'h00,
   parameter logic [5:0] BREAK_ADDR = 6'h30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enp,
   input  logic       scan_en,
   input  logic       deb_en,
   input  logic       kr1_n,
   input  logic       kr2_n,
   output logic [5:0] k,
   output logic [7:0] kbcode,
   output logic       key_down,
   output logic       shift_down,
   output logic       kbd_irq,
   output logic       brk_irq
);

   // Debounce states. CONFIRM waits one scan revisit before accepting a
   // press. RELEASE waits one scan revisit before accepting a release.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_DOWN    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] k_q, k_d;
   logic [5:0] cmp_q, cmp_d;
   logic [7:0] kbcode_q, kbcode_d;
   logic       key_down_q, key_down_d;
   logic       shift_q, shift_d;
   logic       ctrl_q, ctrl_d;
   logic       brk_q, brk_d;
   logic       kbd_irq_q, kbd_irq_d;
   logic       brk_irq_q, brk_irq_d;
   logic       match;

   // The compare latch holds the address that was first seen low. The state
   // machine acts only when the scan comes back around to that address.
   assign match = (cmp_q == k_q);

   // State register. Every output is taken directly from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         k_q        <= 6'h00;
         cmp_q      <= 6'h00;
         kbcode_q   <= 8'h00;
         key_down_q <= 1'b0;
         shift_q    <= 1'b0;
         ctrl_q     <= 1'b0;
         brk_q      <= 1'b0;
         kbd_irq_q  <= 1'b0;
         brk_irq_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cmp_q      <= cmp_d;
         kbcode_q   <= kbcode_d;
         key_down_q <= key_down_d;
         shift_q    <= shift_d;
         ctrl_q     <= ctrl_d;
         brk_q      <= brk_d;
         kbd_irq_q  <= kbd_irq_d;
         brk_irq_q  <= brk_irq_d;
      end
   end

   // Next-state logic.
   //
   // A low scan_en overrides enp and parks the scanner. kbcode and the
   // compare latch are left untouched when the scanner is parked.
   //
   // When a key is accepted, the modifier bits in kbcode come from the
   // latch values before this step. A modifier sampled on the same step
   // therefore appears only in a later key code.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cmp_d      = cmp_q;
      kbcode_d   = kbcode_q;
      key_down_d = key_down_q;
      shift_d    = shift_q;
      ctrl_d     = ctrl_q;
      brk_d      = brk_q;
      kbd_irq_d  = 1'b0;
      brk_irq_d  = 1'b0;

      if (!scan_en) begin
         k_d        = 6'h00;
         state_d    = ST_IDLE;
         key_down_d = 1'b0;
         shift_d    = 1'b0;
         ctrl_d     = 1'b0;
         brk_d      = 1'b0;
      end else if (enp) begin
         k_d = k_q + 6'd1;

         if (k_q == SHIFT_ADDR) begin
            shift_d = ~kr2_n;
         end
         if (k_q == CTRL_ADDR) begin
            ctrl_d = ~kr2_n;
         end
         if (k_q == BREAK_ADDR) begin
            brk_d     = ~kr2_n;
            brk_irq_d = ~kr2_n & ~brk_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (!kr1_n) begin
                  cmp_d = k_q;
                  if (deb_en) begin
                     state_d = ST_CONFIRM;
                  end else begin
                     kbcode_d   = {ctrl_q, shift_q, k_q};
                     key_down_d = 1'b1;
                     kbd_irq_d  = 1'b1;
                     state_d    = ST_DOWN;
                  end
               end
            end
            ST_CONFIRM: begin
               if (match) begin
                  if (!kr1_n) begin
                     kbcode_d   = {ctrl_q, shift_q, cmp_q};
                     key_down_d = 1'b1;
                     kbd_irq_d  = 1'b1;
                     state_d    = ST_DOWN;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DOWN: begin
               if (match && kr1_n) begin
                  if (deb_en) begin
                     state_d = ST_RELEASE;
                  end else begin
                     state_d    = ST_IDLE;
                     key_down_d = 1'b0;
                  end
               end
            end
            ST_RELEASE: begin
               if (match) begin
                  if (kr1_n) begin
                     state_d    = ST_IDLE;
                     key_down_d = 1'b0;
                  end else begin
                     state_d = ST_DOWN;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign k          = k_q;
   assign kbcode     = kbcode_q;
   assign key_down   = key_down_q;
   assign shift_down = shift_q;
   assign kbd_irq    = kbd_irq_q;
   assign brk_irq    = brk_irq_q;

endmodule

// File: tb/tb_pokey_kbd_scan.sv
// tb_pokey_kbd_scan
// ---------------------------------------------------------------------------
// Directed testbench for pokey_kbd_scan.
//
// A behavioural keyboard matrix drives kr1_n and kr2_n from the scan
// address. Every expected interrupt event is queued when its stimulus is
// issued. A monitor on the falling clock edge pops one entry for each
// kbd_irq or brk_irq pulse and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_pokey_kbd_scan;

   logic       clk;
   logic       rst_n;
   logic       enp;
   logic       scan_en;
   logic       deb_en;
   logic       kr1_n;
   logic       kr2_n;
   logic [5:0] k;
   logic [7:0] kbcode;
   logic       key_down;
   logic       shift_down;
   logic       kbd_irq;
   logic       brk_irq;

   // Keyboard matrix model
   logic       keyPressed;
   logic [5:0] keyAddr;
   logic       shiftHeld;
   logic       ctrlHeld;
   logic       brkHeld;

   typedef struct packed {
      logic       isBrk;
      logic [7:0] code;
   } expect_t;

   expect_t sbQueue[$];
   expect_t monExp;
   int      checks   = 0;
   int      failures = 0;

   pokey_kbd_scan #(
      .SHIFT_ADDR (6'h10),
      .CTRL_ADDR  (6'h00),
      .BREAK_ADDR (6'h30)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enp        (enp),
      .scan_en    (scan_en),
      .deb_en     (deb_en),
      .kr1_n      (kr1_n),
      .kr2_n      (kr2_n),
      .k          (k),
      .kbcode     (kbcode),
      .key_down   (key_down),
      .shift_down (shift_down),
      .kbd_irq    (kbd_irq),
      .brk_irq    (brk_irq)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The matrix answers the address that is currently being scanned.
   assign kr1_n = !(keyPressed && (k == keyAddr));
   assign kr2_n = !((shiftHeld && (k == 6'h10)) ||
                    (ctrlHeld  && (k == 6'h00)) ||
                    (brkHeld   && (k == 6'h30)));

   // Monitor: each interrupt pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (kbd_irq) begin
            checks++;
            if (sbQueue.size() == 0) begin
               failures++;
               $display("[TB] FAIL kbdEvent unexpected kbd_irq kbcode=%h required=no event", kbcode);
            end else begin
               monExp = sbQueue.pop_front();
               if (monExp.isBrk || (kbcode !== monExp.code) || (key_down !== 1'b1)) begin
                  failures++;
                  $display("[TB] FAIL kbdEvent kbcode=%h key_down=%b required isBrk=%b kbcode=%h key_down=1",
                           kbcode, key_down, monExp.isBrk, monExp.code);
               end
            end
         end
         if (brk_irq) begin
            checks++;
            if (sbQueue.size() == 0) begin
               failures++;
               $display("[TB] FAIL brkEvent unexpected brk_irq required=no event");
            end else begin
               monExp = sbQueue.pop_front();
               if (!monExp.isBrk) begin
                  failures++;
                  $display("[TB] FAIL brkEvent got brk_irq required kbd event kbcode=%h", monExp.code);
               end
            end
         end
      end
   end

   // Compare one observed value against the value the bench requires.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Step at least once, then until addr is the next address to be evaluated.
   task automatic waitK(input logic [5:0] addr);
      int n;
      n = 0;
      tick();
      while ((k !== addr) && (n < 200)) begin
         tick();
         n++;
      end
      if (k !== addr) begin
         checks++;
         failures++;
         $display("[TB] FAIL waitK timeout k=%0h required=%0h", k, addr);
      end
   endtask

   // Step until kbd_irq is seen, with a bounded budget.
   task automatic waitIrq();
      int n;
      n = 0;
      while (!kbd_irq && (n < 200)) begin
         tick();
         n++;
      end
      if (!kbd_irq) begin
         checks++;
         failures++;
         $display("[TB] FAIL waitIrq timeout kbd_irq=%b required=1", kbd_irq);
      end
   endtask

   // Step until key_down clears, with a bounded budget.
   task automatic waitKeyUp();
      int n;
      n = 0;
      while (key_down && (n < 300)) begin
         tick();
         n++;
      end
      if (key_down) begin
         checks++;
         failures++;
         $display("[TB] FAIL waitKeyUp timeout key_down=%b required=0", key_down);
      end
   endtask

   task automatic pushKbd(input logic [7:0] code);
      sbQueue.push_back('{isBrk: 1'b0, code: code});
   endtask

   task automatic pushBrk();
      sbQueue.push_back('{isBrk: 1'b1, code: 8'h00});
   endtask

   // Directed scenario sequence
   task automatic applyStimulus();
      int n;

      // Reset values
      rst_n      = 1'b0;
      enp        = 1'b0;
      scan_en    = 1'b0;
      deb_en     = 1'b0;
      keyPressed = 1'b0;
      keyAddr    = 6'h25;
      shiftHeld  = 1'b0;
      ctrlHeld   = 1'b0;
      brkHeld    = 1'b0;
      #12;
      checkOutput("resetK",         32'(k),          32'h00);
      checkOutput("resetKbcode",    32'(kbcode),     32'h00);
      checkOutput("resetKeyDown",   32'(key_down),   32'h0);
      checkOutput("resetShiftDown", 32'(shift_down), 32'h0);
      checkOutput("resetKbdIrq",    32'(kbd_irq),    32'h0);
      checkOutput("resetBrkIrq",    32'(brk_irq),    32'h0);

      @(negedge clk);
      rst_n   = 1'b1;
      scan_en = 1'b1;
      deb_en  = 1'b1;
      enp     = 1'b1;

      // Bounce: key low for one visit only, CONFIRM falls back to IDLE
      waitK(6'h25);
      keyPressed = 1'b1;
      tick();
      keyPressed = 1'b0;
      repeat (70) tick();
      checkOutput("bounceKeyDown", 32'(key_down), 32'h0);

      // Debounced accept of 0x25, 64 steps after detection
      waitK(6'h25);
      keyPressed = 1'b1;
      pushKbd(8'h25);
      tick();
      n = 0;
      while (!kbd_irq && (n < 200)) begin
         tick();
         n++;
      end
      checkOutput("acceptLatency", 32'(n),        32'd64);
      checkOutput("acceptKbcode",  32'(kbcode),   32'h25);
      checkOutput("acceptKeyDown", 32'(key_down), 32'h1);

      // Lift straight after acceptance; release takes two revisits
      keyPressed = 1'b0;
      tick();
      checkOutput("kbdIrqWidth", 32'(kbd_irq), 32'h0);
      n = 1;
      while (key_down && (n < 300)) begin
         tick();
         n++;
      end
      checkOutput("releaseLatency", 32'(n), 32'd128);

      // SHIFT held before the press
      shiftHeld = 1'b1;
      waitK(6'h11);
      checkOutput("shiftDown", 32'(shift_down), 32'h1);
      keyPressed = 1'b1;
      waitK(6'h25);
      pushKbd(8'h65);
      waitIrq();
      keyPressed = 1'b0;
      waitKeyUp();

      // SHIFT plus CTRL
      ctrlHeld = 1'b1;
      waitK(6'h01);
      keyPressed = 1'b1;
      waitK(6'h25);
      pushKbd(8'hE5);
      waitIrq();

      // Re-press during RELEASE returns to DOWN without a new irq
      keyPressed = 1'b0;
      waitK(6'h26);
      checkOutput("keyDownInRelease", 32'(key_down), 32'h1);
      keyPressed = 1'b1;
      waitK(6'h26);
      checkOutput("keyDownRepress", 32'(key_down), 32'h1);
      waitK(6'h26);
      checkOutput("keyDownHeld", 32'(key_down), 32'h1);
      keyPressed = 1'b0;
      n = 0;
      while (key_down && (n < 300)) begin
         tick();
         n++;
      end
      checkOutput("releaseLatencyRepress", 32'(n), 32'd128);

      // Drop modifiers, then run without debounce at the wrap address
      shiftHeld = 1'b0;
      ctrlHeld  = 1'b0;
      waitK(6'h20);
      checkOutput("shiftCleared", 32'(shift_down), 32'h0);
      deb_en     = 1'b0;
      keyAddr    = 6'h3F;
      keyPressed = 1'b1;
      waitK(6'h3F);
      pushKbd(8'h3F);
      tick();
      checkOutput("directIrq",     32'(kbd_irq),  32'h1);
      checkOutput("kWrap",         32'(k),        32'h00);
      checkOutput("directKbcode",  32'(kbcode),   32'h3F);
      checkOutput("directKeyDown", 32'(key_down), 32'h1);
      keyPressed = 1'b0;
      waitK(6'h00);
      checkOutput("directRelease", 32'(key_down), 32'h0);

      // BREAK held over three scans gives a single pulse
      deb_en  = 1'b1;
      brkHeld = 1'b1;
      pushBrk();
      repeat (192) tick();
      brkHeld = 1'b0;
      waitK(6'h31);

      // scan_en dropped while a key is down
      keyAddr   = 6'h25;
      shiftHeld = 1'b1;
      waitK(6'h11);
      keyPressed = 1'b1;
      waitK(6'h25);
      pushKbd(8'h65);
      waitIrq();
      repeat (3) tick();
      scan_en = 1'b0;
      tick();
      checkOutput("scanOffK",         32'(k),          32'h00);
      checkOutput("scanOffKeyDown",   32'(key_down),   32'h0);
      checkOutput("scanOffShiftDown", 32'(shift_down), 32'h0);
      checkOutput("scanOffKbcode",    32'(kbcode),     32'h65);
      repeat (3) tick();
      checkOutput("scanOffKHeld", 32'(k), 32'h00);

      // enp low leaves the scan address frozen
      keyPressed = 1'b0;
      shiftHeld  = 1'b0;
      enp        = 1'b0;
      scan_en    = 1'b1;
      repeat (5) tick();
      checkOutput("enpIdleK", 32'(k), 32'h00);
      enp = 1'b1;
      repeat (3) tick();
      checkOutput("enpRunK", 32'(k), 32'h03);

      // Async reset lands while kbd_irq is high
      keyPressed = 1'b1;
      waitK(6'h25);
      waitIrq();
      rst_n = 1'b0;
      #1;
      checkOutput("midResetK",         32'(k),          32'h00);
      checkOutput("midResetKbcode",    32'(kbcode),     32'h00);
      checkOutput("midResetKeyDown",   32'(key_down),   32'h0);
      checkOutput("midResetShiftDown", 32'(shift_down), 32'h0);
      checkOutput("midResetKbdIrq",    32'(kbd_irq),    32'h0);
      checkOutput("midResetBrkIrq",    32'(brk_irq),    32'h0);
      keyPressed = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("firstStepAfterReset", 32'(k), 32'h01);

      repeat (2) tick();
      checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'd0);
   endtask

   initial begin
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pokey_kbd_scan.md
# pokey_kbd_scan

Keyboard scan and debounce controller for the POKEY core. It drives the 6-bit keyboard scan address and samples the two keyboard return lines. It runs the compare-latch debounce state machine and presents the accepted key code, status bits and interrupt pulses to the register file. This block is the producer side of the compare-bit scheme: it decides when the compare latch loads the scan address, and it acts on the mismatch result.

## Interface
Parameters:
- SHIFT_ADDR, 6'h10, scan address at which kr2_n reports SHIFT.
- CTRL_ADDR, 6'h00, scan address at which kr2_n reports CTRL.
- BREAK_ADDR, 6'h30, scan address at which kr2_n reports BREAK.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- enp  input  1  scan-rate enable; one scan step per clk with enp=1.
- scan_en  input  1  SKCTL bit 1; 0 holds the block idle.
- deb_en  input  1  SKCTL bit 0; 1 enables debounce.
- kr1_n  input  1  key return, active low, valid for current k.
- kr2_n  input  1  modifier/break return, active low.
- k  output  6  scan address to keyboard matrix.
- kbcode  output  8  {ctrl, shift, code[5:0]} of last accepted key.
- key_down  output  1  SKSTAT key-depressed, active high.
- shift_down  output  1  SKSTAT shift-depressed, active high.
- kbd_irq  output  1  one-clk pulse on key acceptance.
- brk_irq  output  1  one-clk pulse on BREAK press.

## Operation
- Reset values: k=0, kbcode=8'h00, key_down=0, shift_down=0, kbd_irq=0, brk_irq=0, state=IDLE, compare latch cmp=0, ctrl/shift/break latches=0.
- Scan counter:
  - On enp=1 with scan_en=1, the state machine evaluates the current (k, kr1_n, kr2_n).
  - In the same cycle k increments, wrapping 6'h3F to 6'h00.
- Compare latch:
  - cmp loads k only on the IDLE-to-detect transition.
  - The match condition is cmp==k.
- States, evaluated only on enp=1, scan_en=1:
  - IDLE:
    - kr1_n=0 with deb_en=1: cmp<=k, go CONFIRM.
    - kr1_n=0 with deb_en=0: cmp<=k, then accept (below) immediately.
  - CONFIRM, on match:
    - kr1_n=0: accept.
    - kr1_n=1: go IDLE.
    - Non-match addresses are ignored.
  - DOWN, on match with kr1_n=1:
    - deb_en=1: go RELEASE.
    - deb_en=0: go IDLE and clear key_down.
  - RELEASE, on match:
    - kr1_n=1: go IDLE and clear key_down.
    - kr1_n=0: go DOWN.
- Accept action:
  - kbcode <= {ctrl_q, shift_q, cmp_or_k}; the code field is cmp when accepting from CONFIRM and k when accepting directly from IDLE.
  - key_down <= 1, kbd_irq pulses, state <= DOWN.
- Modifiers, sampled on enp=1 regardless of state:
  - k==SHIFT_ADDR: shift_q <= ~kr2_n; shift_down follows shift_q.
  - k==CTRL_ADDR: ctrl_q <= ~kr2_n.
  - k==BREAK_ADDR: brk_q <= ~kr2_n; brk_irq pulses when brk_q goes 0 to 1.
- scan_en=0 (synchronous, every clk, overrides enp):
  - Forces k=0, state=IDLE, key_down=0, shift_down=0, shift_q=ctrl_q=brk_q=0.
  - kbcode is retained.
- deb_en may change at any time; it takes effect at the next enp evaluation.

## Timing
- All outputs are registered. kbd_irq and brk_irq are high for exactly the one clk following the enp sample that caused them.
- kbcode and key_down update in the same edge that asserts kbd_irq.
- Debounced acceptance takes exactly 64 enp steps after first detection (one full scan revisit). Release takes 128 enp steps (two revisits) after the key lifts.
- Non-debounced acceptance happens on the first detecting enp.
- enp=0 cycles change no state, and both irqs stay 0.
- Reset mid-scan clears everything asynchronously, including any pending irq pulse. The first evaluation after reset deasserts is at k=0.
- Simultaneous events:
  - SHIFT/CTRL sampled on the same enp as an accept use the pre-update latch values.
  - A scan_en fall in the same cycle as enp suppresses evaluation.

## Test plan
- Reset, then scan_en=1, deb_en=1, enp every cycle, key at 6'h25 held low -> detect at k=6'h25. kbd_irq pulses 64 enp later, kbcode=8'h25, key_down=1.
- Same key held, plus kr2_n=0 at k=SHIFT_ADDR before the detect -> kbcode=8'h65 and shift_down=1. With kr2_n=0 at CTRL_ADDR as well -> kbcode=8'hE5.
- Key 6'h25 pressed for only one visit (bounce) -> CONFIRM returns to IDLE, no kbd_irq, key_down=0.
- Accepted key released -> key_down clears 128 enp after release. Re-press during RELEASE -> back to DOWN, key_down stays 1, no new irq.
- deb_en=0, key 6'h3F held low -> kbd_irq on the same enp visit, kbcode=8'h3F. The wrap 6'h3F to 6'h00 is checked. A one-visit release clears key_down.
- kr2_n=0 at BREAK_ADDR held for several scans -> a single brk_irq pulse. Then scan_en=0 mid-DOWN -> k=0, key_down=0, kbcode retained; async reset mid-operation -> all outputs at reset values.
